// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared RV32I sizing constants.
// Used by the core, instruction memory and data memory.
package data_memory_pkg;

    localparam int XLEN      = 32;
    localparam int DM_ADDR_W = 16;
    localparam int DM_DEPTH  = 256;

endpackage

// File: rtl/data_memory_if.sv
// data_memory_if: load/store bus between the memory stage and data_memory.
// Signals: we (write enable), addres (word index), wd (write data), rd (read data).
interface data_memory_if
    import data_memory_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = XLEN
);

    logic              we;
    logic [ADDR_W-1:0] addres;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;

    modport master (
        output we,
        output addres,
        output wd,
        input  rd
    );

    modport slave (
        input  we,
        input  addres,
        input  wd,
        output rd
    );

endinterface

// File: rtl/data_memory.sv
// data_memory: word-addressed data RAM, combinational read, synchronous write.
// Ports: clk, rst_n (async, active-low, clears all words), bus (slave side).
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH  = DM_DEPTH,
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = XLEN
) (
    input  logic          clk,
    input  logic          rst_n,
    data_memory_if.slave  bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    assign in_range = ({1'b0, bus.addres} < LIMIT);
    assign idx      = bus.addres[IDX_W-1:0];

    // idx is only trusted once in_range holds, so no aliasing past DEPTH.
    assign bus.rd = in_range ? mem_q[idx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.we && in_range) begin
            mem_q[idx] <= bus.wd;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed self-checking bench for data_memory.
// Drives the interface master side and compares rd against fixed values.
module tb_data_memory;

    import data_memory_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    data_memory_if #(.ADDR_W(DM_ADDR_W), .DATA_W(XLEN)) bus ();

    data_memory #(
        .DEPTH (DM_DEPTH),
        .ADDR_W(DM_ADDR_W),
        .DATA_W(XLEN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Wait for the next rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp;
        n_chk      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        bus.we     = 1'b0;
        bus.addres = '0;
        bus.wd     = '0;

        #1 chk("rst_a0", bus.rd, 32'h0);
        bus.addres = 16'd10;
        #1 chk("rst_a10", bus.rd, 32'h0);
        bus.addres = 16'd255;
        #1 chk("rst_a255", bus.rd, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        bus.we     = 1'b1;
        bus.addres = 16'd10;
        bus.wd     = 32'h19;
        tick();
        chk("wr10", bus.rd, 32'h19);

        bus.addres = 16'd15;
        bus.wd     = 32'h21;
        tick();
        chk("wr15", bus.rd, 32'h21);

        bus.we = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bus.addres = 16'(a);
            bus.wd     = $urandom;
            tick();
            exp = (a == 10) ? 32'h19 :
                  (a == 15) ? 32'h21 : 32'h0;
            chk($sformatf("sweep%0d", a), bus.rd, exp);
        end

        bus.addres = 16'd10;
        bus.wd     = 32'hDEADBEEF;
        bus.we     = 1'b1;
        #1 chk("same_pre", bus.rd, 32'h19);
        tick();
        chk("same_post", bus.rd, 32'hDEADBEEF);

        bus.addres = 16'd300;
        bus.wd     = 32'hFFFFFFFF;
        tick();
        chk("oor_rd", bus.rd, 32'h0);
        bus.we     = 1'b0;
        bus.addres = 16'd44;
        #1 chk("oor_alias", bus.rd, 32'h0);
        bus.addres = 16'd10;
        #1 chk("oor_keep10", bus.rd, 32'hDEADBEEF);

        #2 rst_n = 1'b0;
        #1 chk("mid_rst_imm", bus.rd, 32'h0);
        bus.we     = 1'b1;
        bus.wd     = 32'h55;
        tick();
        chk("rst_edge_wr", bus.rd, 32'h0);
        bus.we     = 1'b0;
        bus.addres = 16'd15;
        #1 chk("rst_a15", bus.rd, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_a15", bus.rd, 32'h0);
        bus.addres = 16'd10;
        #1 chk("post_a10", bus.rd, 32'h0);

        bus.we     = 1'b1;
        bus.addres = 16'd20;
        bus.wd     = 32'h77;
        tick();
        chk("first_wr", bus.rd, 32'h77);
        bus.we     = 1'b0;
        bus.addres = 16'd255;
        bus.wd     = 32'hA5A5A5A5;
        #1 chk("top_pre", bus.rd, 32'h0);
        bus.we = 1'b1;
        tick();
        chk("top_wr", bus.rd, 32'hA5A5A5A5);
        bus.we     = 1'b0;
        bus.addres = 16'd256;
        #1 chk("oor_256", bus.rd, 32'h0);
        bus.addres = 16'd0;
        #1 chk("a0_clean", bus.rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
